mda_vram_fetch: RTL and testbench

MDA_VRAM_FETCH -- requirements
Module: mda_vram_fetch

---
 rtl/mda_pkg.sv | 26 ++
 rtl/mda_vram_fetch_if.sv | 21 ++
 rtl/mda_cpu_port.sv | 68 ++++++
 rtl/mda_vram_fetch.sv | 82 ++++++++
 tb/tb_mda_vram_fetch.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mda_pkg.sv
// rtl/mda_pkg.sv - cell phase constants and host arbiter state type for the MDA VRAM fetcher
package mda_pkg;

    localparam logic [4:0] SEQ_LAST = 5'd17;
    localparam logic [4:0] SEQ_CHAR = 5'd0;
    localparam logic [4:0] SEQ_ATT  = 5'd2;
    localparam logic [4:0] SEQ_CPU0 = 5'd6;
    localparam logic [4:0] SEQ_CPU1 = 5'd12;
    localparam logic [4:0] VRAM_LAT = 5'd2;

    // Each byte is consumed by the pixel path once its read latency has elapsed.
    localparam logic [4:0] SEQ_RD_CHAR = SEQ_CHAR + VRAM_LAT;
    localparam logic [4:0] SEQ_RD_ATT  = SEQ_ATT + VRAM_LAT;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACCESS,
        ACK
    } arb_state_t;

    function automatic logic is_slot(input logic [4:0] seq);
        return (seq == SEQ_CPU0) || (seq == SEQ_CPU1);
    endfunction

endpackage

// File: rtl/mda_vram_fetch_if.sv
// rtl/mda_vram_fetch_if.sv - host request/acknowledge bus into the VRAM fetcher
interface mda_vram_fetch_if #(
    parameter int ADDR_W = 12
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [7:0]        cpu_wdata;
    logic [7:0]        cpu_rdata;
    logic              cpu_ack;

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_ack
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_ack
    );
endinterface

// File: rtl/mda_cpu_port.sv
// rtl/mda_cpu_port.sv - host arbiter: grants one VRAM access per host slot and acks it
module mda_cpu_port
    import mda_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       slot_next,
    input  logic [7:0] vram_rdata,
    output logic       grant,
    mda_vram_fetch_if.slave cpu
);

    localparam logic [1:0] ACC_LAST = 2'(VRAM_LAT - 5'd1);

    arb_state_t state_q;
    logic [1:0] cnt_q;
    logic       rd_q;
    logic       ack_q;
    logic [7:0] rdata_q;

    // The decision is taken one clock early so the host address is on the bus in the slot's first phase.
    assign grant = ((state_q == IDLE) || (state_q == WAIT)) && cpu.cpu_req && slot_next;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rd_q    <= 1'b0;
            ack_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            ack_q <= 1'b0;
            case (state_q)
                IDLE, WAIT: begin
                    if (grant) begin
                        state_q <= ACCESS;
                        cnt_q   <= '0;
                        rd_q    <= !cpu.cpu_we;
                    end else if (cpu.cpu_req) begin
                        state_q <= WAIT;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                ACCESS: begin
                    if (cnt_q == ACC_LAST) begin
                        state_q <= ACK;
                        ack_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 2'd1;
                    end
                end
                ACK: begin
                    state_q <= IDLE;
                    if (rd_q) begin
                        rdata_q <= vram_rdata;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Read data arrives during the ack clock itself, so it is forwarded then and held afterwards.
    assign cpu.cpu_ack   = ack_q;
    assign cpu.cpu_rdata = (ack_q && rd_q) ? vram_rdata : rdata_q;

endmodule

// File: rtl/mda_vram_fetch.sv
// rtl/mda_vram_fetch.sv - MDA character-cell VRAM sequencer with interleaved host access slots
module mda_vram_fetch
    import mda_pkg::*;
#(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-2:0] crtc_addr,
    output logic [ADDR_W-1:0] vram_addr,
    output logic              vram_we,
    output logic [7:0]        vram_wdata,
    input  logic [7:0]        vram_rdata,
    output logic [4:0]        clk_seq,
    output logic              vram_read_char,
    output logic              vram_read_att,
    output logic              charrom_read,
    output logic              disp_pipeline,
    output logic              crtc_clk,
    mda_vram_fetch_if.slave   cpu
);

    logic [4:0]        seq_q, seq_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q;
    logic [7:0]        wdata_q;
    logic              rd_char_q, rd_att_q, cell_end_q;
    logic              grant;

    mda_cpu_port u_cpu_port (
        .clk        (clk),
        .reset_n    (reset_n),
        .slot_next  (is_slot(seq_d)),
        .vram_rdata (vram_rdata),
        .grant      (grant),
        .cpu        (cpu)
    );

    // Outputs are registered from the next phase so every strobe lines up with clk_seq.
    always_comb begin
        seq_d  = (seq_q == SEQ_LAST) ? '0 : seq_q + 5'd1;
        addr_d = addr_q;
        if (seq_d == SEQ_CHAR) begin
            addr_d = {crtc_addr, 1'b0};
        end else if (seq_d == SEQ_ATT) begin
            addr_d = {crtc_addr, 1'b1};
        end else if (grant) begin
            addr_d = cpu.cpu_addr;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            seq_q      <= '0;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            rd_char_q  <= 1'b0;
            rd_att_q   <= 1'b0;
            cell_end_q <= 1'b0;
        end else begin
            seq_q      <= seq_d;
            addr_q     <= addr_d;
            we_q       <= grant && cpu.cpu_we;
            wdata_q    <= grant ? cpu.cpu_wdata : '0;
            rd_char_q  <= (seq_d == SEQ_RD_CHAR);
            rd_att_q   <= (seq_d == SEQ_RD_ATT);
            cell_end_q <= (seq_d == SEQ_LAST);
        end
    end

    assign clk_seq        = seq_q;
    assign vram_addr      = addr_q;
    assign vram_we        = we_q;
    assign vram_wdata     = wdata_q;
    assign vram_read_char = rd_char_q;
    assign vram_read_att  = rd_att_q;
    assign charrom_read   = cell_end_q;
    assign disp_pipeline  = cell_end_q;
    assign crtc_clk       = cell_end_q;

endmodule

// File: tb/tb_mda_vram_fetch.sv
// tb/tb_mda_vram_fetch.sv - self-checking bench for mda_vram_fetch
module tb_mda_vram_fetch;

    localparam int AW = 12;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [AW-2:0] crtc_addr;
    logic [AW-1:0] vram_addr;
    logic          vram_we;
    logic [7:0]    vram_wdata;
    logic [7:0]    vram_rdata;
    logic [4:0]    clk_seq;
    logic          vram_read_char, vram_read_att, charrom_read, disp_pipeline, crtc_clk;

    mda_vram_fetch_if #(.ADDR_W(AW)) cpu_if ();

    mda_vram_fetch #(.ADDR_W(AW)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .crtc_addr      (crtc_addr),
        .vram_addr      (vram_addr),
        .vram_we        (vram_we),
        .vram_wdata     (vram_wdata),
        .vram_rdata     (vram_rdata),
        .clk_seq        (clk_seq),
        .vram_read_char (vram_read_char),
        .vram_read_att  (vram_read_att),
        .charrom_read   (charrom_read),
        .disp_pipeline  (disp_pipeline),
        .crtc_clk       (crtc_clk),
        .cpu            (cpu_if)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc;

    // Cell phase in the reference model is simply clocks since reset release, modulo 18.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    function automatic logic [7:0] seed(input logic [11:0] a);
        return ~a[7:0] ^ {a[11:8], a[11:8]};
    endfunction

    // VRAM model: unwritten bytes hold a seed pattern, data returns two clocks after the address.
    logic [7:0] vmem [4096];
    bit         vwr  [4096];
    logic [7:0] pipe1;
    always @(posedge clk) begin
        if (vram_we) begin
            vmem[vram_addr] <= vram_wdata;
            vwr[vram_addr]  <= 1'b1;
        end
        pipe1      <= vwr[vram_addr] ? vmem[vram_addr] : seed(vram_addr);
        vram_rdata <= pipe1;
    end

    logic [7:0] ref_val [4096];
    bit         ref_wr  [4096];

    function automatic logic [7:0] ref_read(input logic [11:0] a);
        return ref_wr[a] ? ref_val[a] : seed(a);
    endfunction

    function automatic logic [11:0] video_addr(input logic [10:0] c, input bit att);
        return 12'(c) * 12'd2 + (att ? 12'd1 : 12'd0);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic goto_phase(input int p);
        do step(); while ((cyc % 18) != p);
    endtask

    task automatic host_drive(input bit req, input bit we, input logic [11:0] a, input logic [7:0] d);
        cpu_if.cpu_req   = req;
        cpu_if.cpu_we    = we;
        cpu_if.cpu_addr  = a;
        cpu_if.cpu_wdata = d;
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        crtc_addr = '0;
        host_drive(0, 0, '0, '0);
        repeat (3) step();
        total++; if (clk_seq !== 5'd0) begin bad++; $display("FAIL reset_seq got=%0d exp=0", clk_seq); end
        total++; if (vram_addr !== 12'h000) begin bad++; $display("FAIL reset_addr got=%h exp=000", vram_addr); end
        total++; if ({vram_we, vram_wdata} !== 9'h000) begin bad++; $display("FAIL reset_wr got=%h exp=000", {vram_we, vram_wdata}); end
        total++; if ({vram_read_char, vram_read_att, charrom_read, disp_pipeline, crtc_clk} !== 5'b0)
            begin bad++; $display("FAIL reset_strobes got=%b exp=00000", {vram_read_char, vram_read_att, charrom_read, disp_pipeline, crtc_clk}); end
        total++; if ({cpu_if.cpu_ack, cpu_if.cpu_rdata} !== 9'h000) begin bad++; $display("FAIL reset_cpu got=%h exp=000", {cpu_if.cpu_ack, cpu_if.cpu_rdata}); end
        reset_n = 1'b1;
        step();
        total++; if (clk_seq !== 5'd1) begin bad++; $display("FAIL reset_first_edge got=%0d exp=1", clk_seq); end
    endtask

    task automatic test_free_run();
        logic [10:0] cur;
        logic [11:0] exp_addr;
        int p;
        logic [4:0] exp_str;
        goto_phase(17);
        crtc_addr = 11'h123;
        cur = crtc_addr;
        exp_addr = '0;
        for (int i = 0; i < 108; i++) begin
            step();
            p = cyc % 18;
            if (p == 0) exp_addr = video_addr(cur, 0);
            if (p == 2) exp_addr = video_addr(cur, 1);
            exp_str = {p == 2, p == 4, p == 17, p == 17, p == 17};
            total++; if (clk_seq !== 5'(p)) begin bad++; $display("FAIL run_seq got=%0d exp=%0d", clk_seq, p); end
            total++; if ({vram_read_char, vram_read_att, charrom_read, disp_pipeline, crtc_clk} !== exp_str)
                begin bad++; $display("FAIL run_strobes p=%0d got=%b exp=%b", p, {vram_read_char, vram_read_att, charrom_read, disp_pipeline, crtc_clk}, exp_str); end
            total++; if (vram_addr !== exp_addr) begin bad++; $display("FAIL run_addr p=%0d got=%h exp=%h", p, vram_addr, exp_addr); end
            total++; if (vram_we !== 1'b0) begin bad++; $display("FAIL run_we p=%0d got=%b exp=0", p, vram_we); end
            if (p == 17 && i >= 53) begin
                crtc_addr = 11'($urandom);
                cur = crtc_addr;
            end
        end
    endtask

    task automatic test_read();
        int p;
        goto_phase(3);
        host_drive(1, 0, 12'h0A5, 8'h00);
        do begin
            step();
            p = cyc % 18;
            if (p == 6) begin
                total++; if (vram_addr !== 12'h0A5) begin bad++; $display("FAIL read_addr got=%h exp=0a5", vram_addr); end
            end
            total++; if (vram_we !== 1'b0) begin bad++; $display("FAIL read_we p=%0d got=%b exp=0", p, vram_we); end
            total++; if (cpu_if.cpu_ack !== (p == 8)) begin bad++; $display("FAIL read_ack p=%0d got=%b exp=%b", p, cpu_if.cpu_ack, p == 8); end
            if (p == 8) begin
                total++; if (cpu_if.cpu_rdata !== 8'h5A) begin bad++; $display("FAIL read_data got=%h exp=5a", cpu_if.cpu_rdata); end
                cpu_if.cpu_req = 1'b0;
            end
        end while (p != 10);
        total++; if (cpu_if.cpu_rdata !== 8'h5A) begin bad++; $display("FAIL read_hold got=%h exp=5a", cpu_if.cpu_rdata); end
    endtask

    task automatic test_write();
        int p;
        goto_phase(7);
        host_drive(1, 1, 12'h010, 8'h3C);
        do begin
            step();
            p = cyc % 18;
            total++; if (vram_we !== (p == 12)) begin bad++; $display("FAIL write_we p=%0d got=%b exp=%b", p, vram_we, p == 12); end
            if (p == 12) begin
                total++; if ({vram_addr, vram_wdata} !== 20'h0103C) begin bad++; $display("FAIL write_bus got=%h exp=0103c", {vram_addr, vram_wdata}); end
            end
            total++; if (cpu_if.cpu_ack !== (p == 14)) begin bad++; $display("FAIL write_ack p=%0d got=%b exp=%b", p, cpu_if.cpu_ack, p == 14); end
        end while (p != 14);
        cpu_if.cpu_req = 1'b0;
        ref_val[12'h010] = 8'h3C; ref_wr[12'h010] = 1'b1;
    endtask

    task automatic test_back_to_back();
        int p;
        goto_phase(3);
        host_drive(1, 1, 12'h200, 8'h77);
        for (int i = 0; i < 30; i++) begin
            step();
            p = cyc % 18;
            total++; if (vram_we !== (i < 12 && (p == 6 || p == 12))) begin bad++; $display("FAIL b2b_we i=%0d got=%b", i, vram_we); end
            if (vram_we === 1'b1) begin
                total++; if ({vram_addr, vram_wdata} !== 20'h20077) begin bad++; $display("FAIL b2b_bus got=%h exp=20077", {vram_addr, vram_wdata}); end
            end
            total++; if (cpu_if.cpu_ack !== (i < 12 && (p == 8 || p == 14))) begin bad++; $display("FAIL b2b_ack i=%0d got=%b", i, cpu_if.cpu_ack); end
            if (i < 12 && p == 14) cpu_if.cpu_req = 1'b0;
        end
        ref_val[12'h200] = 8'h77; ref_wr[12'h200] = 1'b1;
    endtask

    task automatic test_cancel();
        int p;
        goto_phase(3);
        host_drive(1, 1, 12'h3FF, 8'hEE);
        goto_phase(5);
        cpu_if.cpu_req = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            p = cyc % 18;
            total++; if ({vram_we, cpu_if.cpu_ack} !== 2'b00) begin bad++; $display("FAIL cancel_quiet p=%0d got=%b exp=00", p, {vram_we, cpu_if.cpu_ack}); end
            if (p == 6) begin
                total++; if (vram_addr !== video_addr(crtc_addr, 1)) begin bad++; $display("FAIL cancel_addr got=%h exp=%h", vram_addr, video_addr(crtc_addr, 1)); end
            end
        end
    endtask

    task automatic test_random_host();
        int d, r, t, p;
        bit we;
        logic [11:0] a;
        logic [7:0] dt;
        for (int k = 0; k < 40; k++) begin
            d = 1 + int'($urandom % 25);
            repeat (d) step();
            we = 1'($urandom);
            a  = 12'h100 + 12'($urandom % 16);
            dt = 8'($urandom);
            host_drive(1, we, a, dt);
            r = cyc;
            t = r + 1;
            while ((t % 18) != 6 && (t % 18) != 12) t++;
            while (cyc < t + 2) begin
                step();
                p = cyc % 18;
                if (cyc == t) begin
                    total++; if ({vram_addr, vram_we} !== {a, we}) begin bad++; $display("FAIL rnd_grant k=%0d got=%h exp=%h", k, {vram_addr, vram_we}, {a, we}); end
                    if (we) begin
                        total++; if (vram_wdata !== dt) begin bad++; $display("FAIL rnd_wdata k=%0d got=%h exp=%h", k, vram_wdata, dt); end
                    end
                end else begin
                    total++; if (vram_we !== 1'b0) begin bad++; $display("FAIL rnd_we k=%0d got=%b exp=0", k, vram_we); end
                end
                total++; if (cpu_if.cpu_ack !== (cyc == t + 2)) begin bad++; $display("FAIL rnd_ack k=%0d got=%b exp=%b", k, cpu_if.cpu_ack, cyc == t + 2); end
                if (p == 0 || p == 2) begin
                    total++; if (vram_addr !== video_addr(crtc_addr, p == 2)) begin bad++; $display("FAIL rnd_video p=%0d got=%h exp=%h", p, vram_addr, video_addr(crtc_addr, p == 2)); end
                end
            end
            if (!we) begin
                total++; if (cpu_if.cpu_rdata !== ref_read(a)) begin bad++; $display("FAIL rnd_rdata k=%0d got=%h exp=%h", k, cpu_if.cpu_rdata, ref_read(a)); end
            end else begin
                ref_val[a] = dt; ref_wr[a] = 1'b1;
            end
            cpu_if.cpu_req = 1'b0;
        end
    endtask

    task automatic test_reset_mid_access();
        goto_phase(3);
        host_drive(1, 0, 12'h050, 8'h00);
        goto_phase(6);
        total++; if (vram_addr !== 12'h050) begin bad++; $display("FAIL rst_mid_grant got=%h exp=050", vram_addr); end
        step();
        reset_n = 1'b0;
        #1;
        total++; if ({clk_seq, vram_addr, vram_we, vram_wdata} !== 26'h0) begin bad++; $display("FAIL rst_mid_bus got=%h exp=0", {clk_seq, vram_addr, vram_we, vram_wdata}); end
        total++; if ({vram_read_char, vram_read_att, charrom_read, disp_pipeline, crtc_clk, cpu_if.cpu_ack, cpu_if.cpu_rdata} !== 14'h0)
            begin bad++; $display("FAIL rst_mid_out got=%h exp=0", {vram_read_char, vram_read_att, charrom_read, disp_pipeline, crtc_clk, cpu_if.cpu_ack, cpu_if.cpu_rdata}); end
        cpu_if.cpu_req = 1'b0;
        repeat (2) step();
        reset_n = 1'b1;
        step();
        total++; if (clk_seq !== 5'd1) begin bad++; $display("FAIL rst_mid_restart got=%0d exp=1", clk_seq); end
        for (int i = 0; i < 20; i++) begin
            step();
            total++; if (cpu_if.cpu_ack !== 1'b0) begin bad++; $display("FAIL rst_mid_ack i=%0d got=%b exp=0", i, cpu_if.cpu_ack); end
        end
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_read();
        test_write();
        test_back_to_back();
        test_cancel();
        test_random_host();
        test_reset_mid_access();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
